// File: rtl/text_cell_buffer.sv
`timescale 1ns/1ps
// ROWS x COLS glyph-ID screen store with a queued write/scroll/clear command path and a registered read port.
// Build macro SCROLL_RING_EN: scroll rotates a base-row pointer and blanks one row instead of copying the screen.
module text_cell_buffer #(
    parameter int ROWS      = 7,
    parameter int COLS      = 20,
    parameter int ROW_W     = 4,
    parameter int COL_W     = 6,
    parameter int ID_W      = 8,
    parameter int BLANK_ID  = 128,
    parameter int CMD_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ID_W-1:0]  wr_id,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COL_W-1:0] wr_col,
    input  logic             scroll,
    input  logic             clear,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [ID_W-1:0]  rd_id,
    output logic             busy,
    output logic             cmd_full,
    output logic             err
);
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ID_W-1:0]  BLANK     = ID_W'(BLANK_ID);
    localparam logic [ROW_W-1:0] ROWS_L    = ROW_W'(ROWS);
    localparam logic [COL_W-1:0] COLS_L    = COL_W'(COLS);
    localparam logic [IDX_W-1:0] COLS_I    = IDX_W'(COLS);
    localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(CELLS - 1);
`ifdef SCROLL_RING_EN
    localparam logic [IDX_W-1:0] SCR_LAST  = IDX_W'(COLS - 1);
`else
    localparam logic [IDX_W-1:0] SCR_LAST  = LAST_CELL;
    localparam logic [IDX_W-1:0] COPY_END  = IDX_W'((ROWS - 1) * COLS);
`endif

    typedef enum logic [1:0] {CMD_WR, CMD_SCR, CMD_CLR} cmd_e;
    typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_CLEAR} state_e;
    typedef struct packed {
        cmd_e             op;
        logic [ID_W-1:0]  id;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } cmd_t;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return IDX_W'(r) * COLS_I + IDX_W'(c);
    endfunction

    logic [ID_W-1:0]  r_mem [CELLS];
    cmd_t             r_fifo [CMD_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    state_e           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_err;
    logic [ID_W-1:0]  r_rd_id;

    cmd_t             w_in_cmd, w_head;
    logic             w_in_valid, w_in_err, w_full, w_pop, w_push, w_drop;
    logic             w_we;
    logic [IDX_W-1:0] w_waddr;
    logic [ID_W-1:0]  w_wdata;
    logic [ROW_W-1:0] w_wr_prow, w_rd_prow;

`ifdef SCROLL_RING_EN
    logic [ROW_W-1:0] r_base;
    logic [ROW_W-1:0] w_bot_row;

    function automatic logic [ROW_W-1:0] ring_row(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] b);
        logic [ROW_W:0] s;
        s = {1'b0, r} + {1'b0, b};
        if (s >= {1'b0, ROWS_L}) s = s - {1'b0, ROWS_L};
        return s[ROW_W-1:0];
    endfunction

    // base already advanced on the pop edge, so the new bottom row is the one just behind it
    assign w_bot_row = (r_base == '0) ? ROWS_L - ROW_W'(1) : r_base - ROW_W'(1);
    assign w_wr_prow = ring_row(w_head.row, r_base);
    assign w_rd_prow = ring_row(rd_row, r_base);
`else
    assign w_wr_prow = w_head.row;
    assign w_rd_prow = rd_row;
`endif

    always_comb begin
        w_in_valid = 1'b0;
        w_in_err   = 1'b0;
        w_in_cmd.op  = CMD_WR;
        w_in_cmd.id  = wr_id;
        w_in_cmd.row = wr_row;
        w_in_cmd.col = wr_col;
        if (clear) begin
            w_in_valid  = 1'b1;
            w_in_cmd.op = CMD_CLR;
            w_in_err    = scroll | wr_en;
        end else if (scroll) begin
            w_in_valid  = 1'b1;
            w_in_cmd.op = CMD_SCR;
            w_in_err    = wr_en;
        end else if (wr_en) begin
            if (wr_row < ROWS_L && wr_col < COLS_L) w_in_valid = 1'b1;
            else                                    w_in_err   = 1'b1;
        end
    end

    assign w_head = r_fifo[r_rptr];
    assign w_full = (r_count == CNT_W'(CMD_DEPTH));
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    assign w_push = w_in_valid && (!w_full || w_pop);
    assign w_drop = w_in_valid && w_full && !w_pop;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_idx;
        w_wdata = BLANK;
        case (r_state)
            S_IDLE: if (w_pop && w_head.op == CMD_WR) begin
                w_we    = 1'b1;
                w_waddr = cell_idx(w_wr_prow, w_head.col);
                w_wdata = w_head.id;
            end
            S_SCROLL: begin
                w_we = 1'b1;
`ifdef SCROLL_RING_EN
                w_waddr = IDX_W'(w_bot_row) * COLS_I + r_idx;
`else
                if (r_idx < COPY_END) w_wdata = r_mem[r_idx + COLS_I];
`endif
            end
            S_CLEAR: w_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we)   r_mem[w_waddr]  <= w_wdata;
        if (w_push) r_fifo[r_wptr]  <= w_in_cmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
`ifdef SCROLL_RING_EN
            r_base  <= '0;
`endif
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
            // a fresh error on the same edge as a clear pop stays visible
            if (w_in_err || w_drop)                 r_err <= 1'b1;
            else if (w_pop && w_head.op == CMD_CLR) r_err <= 1'b0;
            case (r_state)
                S_IDLE: if (w_pop) begin
                    r_idx <= '0;
                    if (w_head.op == CMD_SCR) begin
                        r_state <= S_SCROLL;
`ifdef SCROLL_RING_EN
                        r_base  <= (r_base == ROWS_L - ROW_W'(1)) ? '0 : r_base + ROW_W'(1);
`endif
                    end else if (w_head.op == CMD_CLR) begin
                        r_state <= S_CLEAR;
`ifdef SCROLL_RING_EN
                        r_base  <= '0;
`endif
                    end
                end
                S_SCROLL: if (r_idx == SCR_LAST) r_state <= S_IDLE;
                          else                   r_idx   <= r_idx + IDX_W'(1);
                S_CLEAR:  if (r_idx == LAST_CELL) r_state <= S_IDLE;
                          else                    r_idx   <= r_idx + IDX_W'(1);
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_rd_id <= BLANK;
        else if (rd_row < ROWS_L && rd_col < COLS_L) r_rd_id <= r_mem[cell_idx(w_rd_prow, rd_col)];
        else                                       r_rd_id <= BLANK;
    end

    assign rd_id    = r_rd_id;
    assign busy     = (r_state != S_IDLE) || (r_count != '0);
    assign cmd_full = w_full;
    assign err      = r_err;
endmodule
